// File: rtl/save_mode_sel_if.sv
// Key/busy inputs and mode outputs of the tape-save mode selector, bundled for port connection.
interface save_mode_sel_if #(
    parameter int NUM_MODES = 3,
    parameter int ID_W      = 2
);
    logic                 i_next_tgl;
    logic                 i_prev_tgl;
    logic                 i_busy;
    logic [ID_W-1:0]      o_mode_id;
    logic [NUM_MODES-1:0] o_mode_onehot;
    logic                 o_save_turbo;
    logic                 o_mode_changed;
    logic                 o_pending;

    modport master (
        output i_next_tgl, i_prev_tgl, i_busy,
        input  o_mode_id, o_mode_onehot, o_save_turbo, o_mode_changed, o_pending
    );

    modport slave (
        input  i_next_tgl, i_prev_tgl, i_busy,
        output o_mode_id, o_mode_onehot, o_save_turbo, o_mode_changed, o_pending
    );
endinterface

// File: rtl/save_mode_sel.sv
// Tape-save mode selector: synchronises and debounces next/prev keys, cycles a wrapping mode
// index, and defers changes requested during a save until the save completes.
module save_mode_sel #(
    parameter int                   NUM_MODES       = 3,
    parameter int                   ID_W            = 2,
    parameter int                   DEBOUNCE_CYCLES = 16,
    parameter int                   RESET_MODE      = 0,
    parameter logic [NUM_MODES-1:0] TURBO_MASK      = 3'b010
) (
    input  logic            i_clock,
    input  logic            i_reset,
    save_mode_sel_if.slave  bus
);
    localparam int                   CNT_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ID_W-1:0]      LAST_ID      = ID_W'(NUM_MODES - 1);
    localparam logic [ID_W-1:0]      RESET_ID     = ID_W'(RESET_MODE);
    localparam logic [NUM_MODES-1:0] RESET_ONEHOT = NUM_MODES'(1) << RESET_MODE;
    localparam logic                 RESET_TURBO  = TURBO_MASK[RESET_MODE];

    // Bit 0 is the next key, bit 1 the prev key throughout.
    logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]            stable_q, stable_d, stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0]      cnt_q [2];
    logic [CNT_W-1:0]      cnt_d [2];
    logic [1:0]            req;
    logic                  step, step_up;
    logic                  pending_q, pending_d, pend_up_q, pend_up_d;
    logic [ID_W-1:0]       mode_id_q, mode_id_d;
    logic [NUM_MODES-1:0]  onehot_q, onehot_d;
    logic                  turbo_q, turbo_d, changed_q, changed_d;

    always_comb begin
        sync1_d      = {bus.i_prev_tgl, bus.i_next_tgl};
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                stable_d[k] = sync2_q[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // A lone request either steps now or, during a save, replaces the held one;
    // simultaneous next+prev requests cancel and leave the held request alone.
    always_comb begin
        req       = stable_q & ~stable_dly_q;
        step      = 1'b0;
        step_up   = 1'b0;
        pending_d = pending_q;
        pend_up_d = pend_up_q;
        if (req == 2'b01 || req == 2'b10) begin
            if (bus.i_busy) begin
                pending_d = 1'b1;
                pend_up_d = req[0];
            end else begin
                step      = 1'b1;
                step_up   = req[0];
                pending_d = 1'b0;
            end
        end else if (req == 2'b00 && pending_q && !bus.i_busy) begin
            step      = 1'b1;
            step_up   = pend_up_q;
            pending_d = 1'b0;
        end

        mode_id_d = mode_id_q;
        if (step) begin
            if (step_up) begin
                mode_id_d = (mode_id_q == LAST_ID) ? '0 : mode_id_q + ID_W'(1);
            end else begin
                mode_id_d = (mode_id_q == '0) ? LAST_ID : mode_id_q - ID_W'(1);
            end
        end
        onehot_d  = NUM_MODES'(1) << mode_id_d;
        turbo_d   = TURBO_MASK[mode_id_d];
        changed_d = step;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '{default: '0};
            pending_q    <= 1'b0;
            pend_up_q    <= 1'b0;
            mode_id_q    <= RESET_ID;
            onehot_q     <= RESET_ONEHOT;
            turbo_q      <= RESET_TURBO;
            changed_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            pend_up_q    <= pend_up_d;
            mode_id_q    <= mode_id_d;
            onehot_q     <= onehot_d;
            turbo_q      <= turbo_d;
            changed_q    <= changed_d;
        end
    end

    assign bus.o_mode_id      = mode_id_q;
    assign bus.o_mode_onehot  = onehot_q;
    assign bus.o_save_turbo   = turbo_q;
    assign bus.o_mode_changed = changed_q;
    assign bus.o_pending      = pending_q;
endmodule

// File: tb/tb_save_mode_sel.sv
// Bench for save_mode_sel: cycle-level reference model plus directed key/busy/reset scenarios.
module tb_save_mode_sel;
    localparam int N       = 3;
    localparam int D       = 16;
    localparam int TMASK   = 3'b010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   strobes = 0;

    always #5 clk = ~clk;

    save_mode_sel_if #(.NUM_MODES(3), .ID_W(2)) bus ();
    save_mode_sel_if #(.NUM_MODES(5), .ID_W(3)) bus_b ();

    save_mode_sel #(.NUM_MODES(3), .ID_W(2), .DEBOUNCE_CYCLES(16), .RESET_MODE(0),
                    .TURBO_MASK(3'b010)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));
    save_mode_sel #(.NUM_MODES(5), .ID_W(3), .DEBOUNCE_CYCLES(16), .RESET_MODE(4),
                    .TURBO_MASK(5'b10100)) dut_b (.i_clock(clk), .i_reset(rst), .bus(bus_b));

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: keys reach the debouncer two samples late, a key level is accepted
    // once the last D synchronised samples all disagree with the accepted level.
    int         m_id = 0;
    bit         m_pend = 0, m_up = 0, m_chg = 0;
    bit   [1:0] m_stable = 0, m_rose = 0;
    logic [1:0] raw_hist[$];
    logic [1:0] sync_hist[$];

    always @(posedge clk) begin
        logic [1:0] sync_now, new_stable;
        bit         all_diff;
        if (rst) begin
            m_id = 0; m_pend = 0; m_up = 0; m_chg = 0; m_stable = 0; m_rose = 0;
            raw_hist.delete();
            sync_hist.delete();
        end else begin
            m_chg = 0;
            if (m_rose == 2'b01 || m_rose == 2'b10) begin
                if (bus.i_busy) begin
                    m_pend = 1; m_up = m_rose[0];
                end else begin
                    m_id = m_rose[0] ? (m_id + 1) % N : (m_id + N - 1) % N;
                    m_chg = 1; m_pend = 0;
                end
            end else if (m_rose == 2'b00 && m_pend && !bus.i_busy) begin
                m_id = m_up ? (m_id + 1) % N : (m_id + N - 1) % N;
                m_chg = 1; m_pend = 0;
            end
            sync_now = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 2'b00;
            raw_hist.push_back({bus.i_prev_tgl, bus.i_next_tgl});
            if (raw_hist.size() > 4) void'(raw_hist.pop_front());
            sync_hist.push_back(sync_now);
            if (sync_hist.size() > D) void'(sync_hist.pop_front());
            new_stable = m_stable;
            for (int k = 0; k < 2; k++) begin
                all_diff = (sync_hist.size() == D);
                foreach (sync_hist[j]) if (sync_hist[j][k] == m_stable[k]) all_diff = 0;
                if (all_diff) new_stable[k] = ~m_stable[k];
            end
            m_rose   = new_stable & ~m_stable;
            m_stable = new_stable;
        end
        #1;
        check("model_id", bus.o_mode_id, m_id);
        check("model_onehot", bus.o_mode_onehot, 1 << m_id);
        check("model_turbo", bus.o_save_turbo, (TMASK >> m_id) & 1);
        check("model_changed", bus.o_mode_changed, m_chg);
        check("model_pending", bus.o_pending, m_pend);
    end

    always @(posedge clk) begin
        #1;
        if (bus.o_mode_changed === 1'b1) strobes++;
    end

    task automatic press(input bit nxt, input bit prv, input int hold);
        @(negedge clk);
        bus.i_next_tgl = nxt;
        bus.i_prev_tgl = prv;
        repeat (hold) @(negedge clk);
        bus.i_next_tgl = 1'b0;
        bus.i_prev_tgl = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    int s0, lat;
    bit found;
    int bounce[10] = '{3, 5, 2, 7, 11, 1, 14, 4, 9, 2};

    initial begin
        bus.i_next_tgl = 0; bus.i_prev_tgl = 0; bus.i_busy = 0;
        bus_b.i_next_tgl = 0; bus_b.i_prev_tgl = 0; bus_b.i_busy = 0;
        repeat (3) @(negedge clk);
        check("rst_id", bus.o_mode_id, 0);
        check("rst_onehot", bus.o_mode_onehot, 3'b001);
        check("rst_turbo", bus.o_save_turbo, 0);
        check("rst_changed", bus.o_mode_changed, 0);
        check("rst_pending", bus.o_pending, 0);
        check("b_rst_id", bus_b.o_mode_id, 4);
        check("b_rst_onehot", bus_b.o_mode_onehot, 5'b10000);
        check("b_rst_turbo", bus_b.o_save_turbo, 1);
        rst = 0;

        // First press: latency and pulse width.
        @(negedge clk);
        s0 = strobes;
        bus.i_next_tgl = 1;
        found = 0; lat = 0;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(posedge clk); #2;
            if (bus.o_mode_changed === 1'b1) begin found = 1; lat = i; end
        end
        check("latency", lat, 19);
        check("first_id", bus.o_mode_id, 1);
        check("first_onehot", bus.o_mode_onehot, 3'b010);
        check("first_turbo", bus.o_save_turbo, 1);
        @(posedge clk); #2;
        check("pulse_width", bus.o_mode_changed, 0);
        repeat (20) @(negedge clk);
        bus.i_next_tgl = 0;
        repeat (30) @(negedge clk);
        check("first_strobes", strobes - s0, 1);

        s0 = strobes; press(1, 0, 40);
        check("next2_id", bus.o_mode_id, 2);
        check("next2_strobes", strobes - s0, 1);
        s0 = strobes; press(1, 0, 40);
        check("wrap_id", bus.o_mode_id, 0);
        check("wrap_strobes", strobes - s0, 1);
        s0 = strobes; press(0, 1, 40);
        check("prev_wrap_id", bus.o_mode_id, 2);
        check("prev_strobes", strobes - s0, 1);

        s0 = strobes; press(1, 0, 15);
        check("glitch_id", bus.o_mode_id, 2);
        check("glitch_strobes", strobes - s0, 0);

        s0 = strobes;
        foreach (bounce[i]) begin
            bus.i_next_tgl = ~i[0];
            repeat (bounce[i]) @(negedge clk);
        end
        press(1, 0, 40);
        check("bounce_id", bus.o_mode_id, 0);
        check("bounce_strobes", strobes - s0, 1);

        // Deferred requests during a save.
        @(negedge clk);
        bus.i_busy = 1;
        s0 = strobes;
        press(1, 0, 40);
        check("busy_next_id", bus.o_mode_id, 0);
        check("busy_next_pend", bus.o_pending, 1);
        press(0, 1, 40);
        check("busy_prev_id", bus.o_mode_id, 0);
        check("busy_prev_pend", bus.o_pending, 1);
        check("busy_strobes", strobes - s0, 0);
        @(negedge clk);
        bus.i_busy = 0;
        @(posedge clk); #2;
        check("deferred_id", bus.o_mode_id, 2);
        check("deferred_pend", bus.o_pending, 0);
        check("deferred_changed", bus.o_mode_changed, 1);

        s0 = strobes; press(1, 1, 40);
        check("cancel_id", bus.o_mode_id, 2);
        check("cancel_strobes", strobes - s0, 0);
        check("cancel_pend", bus.o_pending, 0);

        // Reset a few clocks before the key would have been accepted.
        @(negedge clk);
        bus.i_next_tgl = 1;
        repeat (13) @(negedge clk);
        rst = 1;
        #1;
        check("async_rst_id", bus.o_mode_id, 0);
        repeat (2) @(negedge clk);
        bus.i_next_tgl = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        s0 = strobes;
        repeat (40) @(negedge clk);
        check("post_rst_id", bus.o_mode_id, 0);
        check("post_rst_strobes", strobes - s0, 0);

        // Key held through reset release produces one step.
        bus.i_next_tgl = 1;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        s0 = strobes;
        repeat (40) @(negedge clk);
        bus.i_next_tgl = 0;
        repeat (30) @(negedge clk);
        check("held_rst_id", bus.o_mode_id, 1);
        check("held_rst_strobes", strobes - s0, 1);

        // Five-mode instance: reset mode 4 is turbo, next wraps to non-turbo mode 0.
        check("b_id_before", bus_b.o_mode_id, 4);
        bus_b.i_next_tgl = 1;
        found = 0; lat = 0;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(posedge clk); #2;
            if (bus_b.o_mode_changed === 1'b1) begin found = 1; lat = i; end
        end
        check("b_latency", lat, 19);
        check("b_id", bus_b.o_mode_id, 0);
        check("b_turbo", bus_b.o_save_turbo, 0);
        check("b_onehot", bus_b.o_mode_onehot, 5'b00001);
        @(negedge clk);
        bus_b.i_next_tgl = 0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
